// File: rtl/fairy_pkg.sv
// Shared MIPS-style opcode/funct constants, decode-stage FSM encoding and
// register-usage helpers. STALL exists only with FAIRY_LOAD_USE_STALL_EN.
package fairy_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;
  localparam logic [5:0] OP_LUI     = 6'h0f;
  localparam logic [5:0] OP_SB      = 6'h28;
  localparam logic [5:0] OP_SH      = 6'h29;
  localparam logic [5:0] OP_SW      = 6'h2b;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;

  localparam logic [4:0] RT_BLTZ = 5'd0;
  localparam logic [4:0] RT_BGEZ = 5'd1;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1
`ifdef FAIRY_LOAD_USE_STALL_EN
    ,
    STALL = 2'd2
`endif
  } state_e;

  // Shift-immediates take their operand from rt only; jumps and LUI read no rs.
  function automatic logic reads_rs(input logic [31:0] inst);
    case (inst[31:26])
      OP_SPECIAL:           return !(inst[5:0] inside {FN_SLL, FN_SRL, FN_SRA});
      OP_J, OP_JAL, OP_LUI: return 1'b0;
      default:              return 1'b1;
    endcase
  endfunction

  function automatic logic reads_rt(input logic [31:0] inst);
    case (inst[31:26])
      OP_SPECIAL:                         return !(inst[5:0] inside {FN_JR, FN_JALR});
      OP_BEQ, OP_BNE, OP_SB, OP_SH, OP_SW: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/fairy_decode_stage_if.sv
// Fetch/regfile/execute-facing signals of the decode stage; master drives the
// stage inputs, slave is the decode stage itself.
interface fairy_decode_stage_if;
  logic [31:0] inst_i;
  logic [31:0] pc_i;
  logic        exception_i;
  logic [31:0] rs_data_i;
  logic [31:0] rt_data_i;
  logic        ex_load_i;
  logic [4:0]  ex_dest_i;
  logic [4:0]  rs_addr_o;
  logic [4:0]  rt_addr_o;
  logic        branch_valid_o;
  logic [31:0] branch_target_o;
  logic        stall_o;
  logic [31:0] inst_o;
  logic [31:0] pc_o;

  modport master (
    output inst_i, pc_i, exception_i, rs_data_i, rt_data_i, ex_load_i, ex_dest_i,
    input  rs_addr_o, rt_addr_o, branch_valid_o, branch_target_o, stall_o, inst_o, pc_o
  );

  modport slave (
    input  inst_i, pc_i, exception_i, rs_data_i, rt_data_i, ex_load_i, ex_dest_i,
    output rs_addr_o, rt_addr_o, branch_valid_o, branch_target_o, stall_o, inst_o, pc_o
  );
endinterface

// File: rtl/fairy_branch_unit.sv
// Combinational branch/jump decode: classification, signed condition
// evaluation and target generation for the instruction at pc_i.
module fairy_branch_unit
  import fairy_pkg::*;
(
  input  logic [31:0] inst_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] rs_data_i,
  input  logic [31:0] rt_data_i,
  output logic        taken_o,
  output logic        is_branch_o,
  output logic [31:0] target_o
);

  logic [31:0]        pc_plus4;
  logic [31:0]        imm_sext;
  logic [31:0]        br_target;
  logic [31:0]        j_target;
  logic signed [31:0] rs_s;

  assign pc_plus4  = pc_i + 32'd4;
  assign imm_sext  = {{16{inst_i[15]}}, inst_i[15:0]};
  assign br_target = pc_plus4 + (imm_sext << 2);
  assign j_target  = {pc_plus4[31:28], inst_i[25:0], 2'b00};
  assign rs_s      = $signed(rs_data_i);

  always_comb begin
    // NOTE: every output gets a default before the case, so no path leaves
    // a variable unassigned and no latch is inferred.
    taken_o     = 1'b0;
    is_branch_o = 1'b0;
    target_o    = br_target;
    case (inst_i[31:26])
      OP_BEQ: begin
        is_branch_o = 1'b1;
        taken_o     = (rs_data_i == rt_data_i);
      end
      OP_BNE: begin
        is_branch_o = 1'b1;
        taken_o     = (rs_data_i != rt_data_i);
      end
      OP_BLEZ: begin
        is_branch_o = 1'b1;
        taken_o     = (rs_s <= 0);
      end
      OP_BGTZ: begin
        is_branch_o = 1'b1;
        taken_o     = (rs_s > 0);
      end
      OP_REGIMM: begin
        if (inst_i[20:16] == RT_BLTZ) begin
          is_branch_o = 1'b1;
          taken_o     = (rs_s < 0);
        end else if (inst_i[20:16] == RT_BGEZ) begin
          is_branch_o = 1'b1;
          taken_o     = (rs_s >= 0);
        end
      end
      OP_J, OP_JAL: begin
        is_branch_o = 1'b1;
        taken_o     = 1'b1;
        target_o    = j_target;
      end
      OP_SPECIAL: begin
        if (inst_i[5:0] == FN_JR || inst_i[5:0] == FN_JALR) begin
          is_branch_o = 1'b1;
          taken_o     = 1'b1;
          target_o    = rs_data_i;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/fairy_decode_stage.sv
// Decode stage: RUN/STALL/FLUSH control, delay-slot tracking and the pipeline
// register to execute. Load-use stalling exists only with FAIRY_LOAD_USE_STALL_EN.
module fairy_decode_stage
  import fairy_pkg::*;
(
  input logic           clk,
  input logic           reset_n,
  fairy_decode_stage_if.slave dec
);

  state_e      state_q, state_d;
  logic [31:0] pc_q;
  logic [31:0] inst_q, inst_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic        ds_q, ds_d;

  logic [31:0] cur_inst;
  logic [31:0] cur_pc;
  logic        hazard;
  logic        pc_load;
  logic        issue;
  logic        br_taken;
  logic        br_is_branch;
  logic [31:0] br_target;
  logic        branch_valid;

`ifdef FAIRY_LOAD_USE_STALL_EN
  logic [31:0] replay_inst_q, replay_inst_d;
  logic [31:0] replay_pc_q, replay_pc_d;
  logic        in_stall;

  // While stalled the held instruction comes from the replay register and
  // the incoming fetch word is ignored.
  assign in_stall = (state_q == STALL);
  assign cur_inst = (state_q == FLUSH) ? '0 : (in_stall ? replay_inst_q : dec.inst_i);
  assign cur_pc   = in_stall ? replay_pc_q : pc_q;
  assign pc_load  = !in_stall;
  assign hazard   = (cur_inst != '0) && dec.ex_load_i && (dec.ex_dest_i != 5'd0) &&
                    ((reads_rs(cur_inst) && dec.ex_dest_i == cur_inst[25:21]) ||
                     (reads_rt(cur_inst) && dec.ex_dest_i == cur_inst[20:16]));

  always_comb begin
    replay_inst_d = replay_inst_q;
    replay_pc_d   = replay_pc_q;
    if (dec.exception_i) begin
      replay_inst_d = '0;
      replay_pc_d   = '0;
    end else if (state_q == RUN && hazard) begin
      replay_inst_d = cur_inst;
      replay_pc_d   = cur_pc;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      replay_inst_q <= '0;
      replay_pc_q   <= '0;
    end else begin
      replay_inst_q <= replay_inst_d;
      replay_pc_q   <= replay_pc_d;
    end
  end
`else
  logic unused_load_inputs;

  assign unused_load_inputs = ^{dec.ex_load_i, dec.ex_dest_i};
  assign cur_inst = (state_q == FLUSH) ? '0 : dec.inst_i;
  assign cur_pc   = pc_q;
  assign pc_load  = 1'b1;
  assign hazard   = 1'b0;
`endif

  fairy_branch_unit u_branch (
    .inst_i      (cur_inst),
    .pc_i        (cur_pc),
    .rs_data_i   (dec.rs_data_i),
    .rt_data_i   (dec.rt_data_i),
    .taken_o     (br_taken),
    .is_branch_o (br_is_branch),
    .target_o    (br_target)
  );

  assign issue        = !dec.exception_i && !hazard && (state_q != FLUSH);
  assign branch_valid = issue && (state_q == RUN) && br_is_branch && br_taken && !ds_q;

  always_comb begin
    state_d = state_q;
    if (dec.exception_i) begin
      state_d = FLUSH;
    end else begin
      case (state_q)
`ifdef FAIRY_LOAD_USE_STALL_EN
        RUN:     if (hazard) state_d = STALL;
        STALL:   if (!hazard) state_d = RUN;
`else
        RUN:     state_d = RUN;
`endif
        FLUSH:   state_d = RUN;
        default: state_d = RUN;
      endcase
    end
  end

  // A branch sitting in a delay slot is squashed to a bubble.
  always_comb begin
    inst_d   = (issue && !(ds_q && br_is_branch)) ? cur_inst : '0;
    pc_out_d = (inst_d != '0) ? cur_pc : '0;
    ds_d     = ds_q;
    if (dec.exception_i) begin
      ds_d = 1'b0;
    end else if (issue && ds_q && cur_inst != '0) begin
      ds_d = 1'b0;
    end else if (issue && br_is_branch) begin
      ds_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (!reset_n) begin
      state_q  <= RUN;
      pc_q     <= '0;
      inst_q   <= '0;
      pc_out_q <= '0;
      ds_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      if (pc_load) pc_q <= dec.pc_i;
      inst_q   <= inst_d;
      pc_out_q <= pc_out_d;
      ds_q     <= ds_d;
    end
  end

  assign dec.rs_addr_o       = reset_n ? cur_inst[25:21] : 5'd0;
  assign dec.rt_addr_o       = reset_n ? cur_inst[20:16] : 5'd0;
  assign dec.stall_o         = reset_n && hazard && !dec.exception_i;
  assign dec.branch_valid_o  = reset_n && branch_valid;
  assign dec.branch_target_o = (reset_n && branch_valid) ? br_target : '0;
  assign dec.inst_o          = inst_q;
  assign dec.pc_o            = pc_out_q;

endmodule

// File: tb/tb_fairy_decode_stage.sv
// Directed self-checking bench for fairy_decode_stage; covers both builds of
// FAIRY_LOAD_USE_STALL_EN.
module tb_fairy_decode_stage;

  localparam logic [31:0] ADDU_A = 32'h01014821; // addu $9,$8,$1
  localparam logic [31:0] ADDU_B = 32'h00014821; // addu $9,$0,$1
  localparam logic [31:0] BEQ_12 = 32'h10220004; // beq  $1,$2,+4
  localparam logic [31:0] JR_31  = 32'h03E00008; // jr   $31

  logic clk = 1'b0;
  logic reset_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  fairy_decode_stage_if dif ();

  fairy_decode_stage dut (
    .clk     (clk),
    .reset_n (reset_n),
    .dec     (dif)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] inst, input logic [31:0] pc,
                       input logic [31:0] rs, input logic [31:0] rt);
    dif.inst_i      = inst;
    dif.pc_i        = pc;
    dif.rs_data_i   = rs;
    dif.rt_data_i   = rt;
    dif.exception_i = 1'b0;
    dif.ex_load_i   = 1'b0;
    dif.ex_dest_i   = 5'd0;
  endtask

  // Filler cycle sets pc_q to pc (and retires any pending delay slot), then
  // the branch is decoded against pc and issued on the following edge.
  task automatic branch_case(input string tag, input logic [31:0] inst, input logic [31:0] pc,
                             input logic [31:0] rs, input logic [31:0] rt,
                             input logic exp_v, input logic [31:0] exp_t);
    drive(ADDU_A, pc, 32'd0, 32'd0);
    tick();
    drive(inst, pc + 32'd4, rs, rt);
    #1;
    check({tag, "_valid"}, 32'(dif.branch_valid_o), 32'(exp_v));
    check({tag, "_target"}, dif.branch_target_o, exp_t);
    tick();
    check({tag, "_inst_o"}, dif.inst_o, inst);
    check({tag, "_pc_o"}, dif.pc_o, pc);
  endtask

  initial begin
    reset_n = 1'b0;
    drive(BEQ_12, 32'hBFC00010, 32'd5, 32'd5);
    #3;
    check("rst_valid", 32'(dif.branch_valid_o), 32'd0);
    check("rst_target", dif.branch_target_o, 32'd0);
    check("rst_stall", 32'(dif.stall_o), 32'd0);
    check("rst_rs_addr", 32'(dif.rs_addr_o), 32'd0);
    check("rst_rt_addr", 32'(dif.rt_addr_o), 32'd0);
    check("rst_inst_o", dif.inst_o, 32'd0);
    check("rst_pc_o", dif.pc_o, 32'd0);
    check("rst_ds", 32'(dut.ds_q), 32'd0);
    tick();
    tick();
    reset_n = 1'b1;

    // BEQ taken at pc 0xBFC00010, then its delay slot
    drive(32'd0, 32'hBFC00010, 32'd0, 32'd0);
    tick();
    drive(BEQ_12, 32'hBFC00014, 32'd5, 32'd5);
    #1;
    check("beq_valid", 32'(dif.branch_valid_o), 32'd1);
    check("beq_target", dif.branch_target_o, 32'hBFC00024);
    check("beq_rs_addr", 32'(dif.rs_addr_o), 32'd1);
    check("beq_rt_addr", 32'(dif.rt_addr_o), 32'd2);
    tick();
    check("beq_inst_o", dif.inst_o, BEQ_12);
    check("beq_pc_o", dif.pc_o, 32'hBFC00010);
    check("beq_ds_set", 32'(dut.ds_q), 32'd1);
    drive(ADDU_A, 32'hBFC00018, 32'd0, 32'd0);
    #1;
    check("slot_valid", 32'(dif.branch_valid_o), 32'd0);
    check("slot_target", dif.branch_target_o, 32'd0);
    tick();
    check("slot_inst_o", dif.inst_o, ADDU_A);
    check("slot_pc_o", dif.pc_o, 32'hBFC00014);
    check("slot_ds_clr", 32'(dut.ds_q), 32'd0);

    branch_case("bne_wrap",  32'h14640001, 32'hFFFFFFF8, 32'd1,        32'd2, 1'b1, 32'h00000000);
    branch_case("beq_nt",    BEQ_12,       32'h00000040, 32'd1,        32'd2, 1'b0, 32'h00000000);
    branch_case("blez_neg",  32'h1840FFFF, 32'h00001000, 32'hFFFFFFFF, 32'd0, 1'b1, 32'h00001000);
    branch_case("bgtz_min",  32'h1C400008, 32'h00001100, 32'h80000000, 32'd0, 1'b0, 32'h00000000);
    branch_case("bltz",      32'h04400010, 32'h00002000, 32'hFFFFFFFB, 32'd0, 1'b1, 32'h00002044);
    branch_case("bgez_zero", 32'h04418000, 32'h00020000, 32'd0,        32'd0, 1'b1, 32'h00000004);
    branch_case("j",         32'h08100000, 32'hBFC00100, 32'd0,        32'd0, 1'b1, 32'hB0400000);
    branch_case("jal_rgn",   32'h0FFFFFFF, 32'h1FFFFFFC, 32'd0,        32'd0, 1'b1, 32'h2FFFFFFC);
    branch_case("jalr",      32'h0080F809, 32'h00000040, 32'h12345678, 32'd0, 1'b1, 32'h12345678);

    // JR with a BEQ in its delay slot
    drive(ADDU_A, 32'h00000300, 32'd0, 32'd0);
    tick();
    drive(JR_31, 32'h00000304, 32'h80000180, 32'd0);
    #1;
    check("jr_valid", 32'(dif.branch_valid_o), 32'd1);
    check("jr_target", dif.branch_target_o, 32'h80000180);
    tick();
    check("jr_inst_o", dif.inst_o, JR_31);
    drive(BEQ_12, 32'h00000308, 32'd7, 32'd7);
    #1;
    check("ds_beq_valid", 32'(dif.branch_valid_o), 32'd0);
    check("ds_beq_target", dif.branch_target_o, 32'd0);
    tick();
    check("ds_beq_inst_o", dif.inst_o, 32'd0);
    check("ds_beq_ds_clr", 32'(dut.ds_q), 32'd0);

    // exception in a delay slot discards ds_q
    drive(BEQ_12, 32'h00000500, 32'd1, 32'd2);
    tick();
    check("exc_ds_set", 32'(dut.ds_q), 32'd1);
    drive(ADDU_A, 32'h00000504, 32'd0, 32'd0);
    dif.exception_i = 1'b1;
    tick();
    check("exc_ds_clr", 32'(dut.ds_q), 32'd0);
    check("exc_ds_inst_o", dif.inst_o, 32'd0);
    drive(32'd0, 32'h00000100, 32'd0, 32'd0);
    tick();

`ifdef FAIRY_LOAD_USE_STALL_EN
    // load-use on rs: one stall cycle, then replay
    drive(ADDU_A, 32'h00000104, 32'd0, 32'd0);
    dif.ex_load_i = 1'b1;
    dif.ex_dest_i = 5'd8;
    #1;
    check("lu_stall", 32'(dif.stall_o), 32'd1);
    check("lu_valid", 32'(dif.branch_valid_o), 32'd0);
    tick();
    check("lu_bubble", dif.inst_o, 32'd0);
    drive(JR_31, 32'h00000108, 32'h00000055, 32'd0);
    #1;
    check("lu_release", 32'(dif.stall_o), 32'd0);
    check("lu_replay_rs", 32'(dif.rs_addr_o), 32'd8);
    check("lu_ign_valid", 32'(dif.branch_valid_o), 32'd0);
    tick();
    check("lu_replay_inst", dif.inst_o, ADDU_A);
    check("lu_replay_pc", dif.pc_o, 32'h00000100);

    drive(ADDU_B, 32'h0000010C, 32'd0, 32'd0);
    dif.ex_load_i = 1'b1;
    dif.ex_dest_i = 5'd0;
    #1;
    check("dest0_stall", 32'(dif.stall_o), 32'd0);
    dif.ex_dest_i = 5'd9;
    #1;
    check("dest_rd_stall", 32'(dif.stall_o), 32'd0);
    dif.ex_dest_i = 5'd1;
    #1;
    check("rt_hazard_stall", 32'(dif.stall_o), 32'd1);
    tick();
    check("rt_hazard_bubble", dif.inst_o, 32'd0);
    dif.exception_i = 1'b1;
    #1;
    check("exc_stall", 32'(dif.stall_o), 32'd0);
    check("exc_valid", 32'(dif.branch_valid_o), 32'd0);
`else
    drive(ADDU_A, 32'h00000104, 32'd0, 32'd0);
    dif.ex_load_i = 1'b1;
    dif.ex_dest_i = 5'd8;
    #1;
    check("nolu_stall", 32'(dif.stall_o), 32'd0);
    tick();
    check("nolu_inst_o", dif.inst_o, ADDU_A);
    check("nolu_pc_o", dif.pc_o, 32'h00000100);
    drive(BEQ_12, 32'h00000108, 32'd3, 32'd3);
    dif.exception_i = 1'b1;
    #1;
    check("exc_stall", 32'(dif.stall_o), 32'd0);
    check("exc_valid", 32'(dif.branch_valid_o), 32'd0);
    check("exc_target", dif.branch_target_o, 32'd0);
`endif

    // flush: two bubble edges, then RUN resumes from inst_i
    tick();
    check("exc_edge1_inst", dif.inst_o, 32'd0);
    check("exc_edge1_pc", dif.pc_o, 32'd0);
    drive(ADDU_A, 32'h00000200, 32'd0, 32'd0);
    #1;
    check("flush_rs_addr", 32'(dif.rs_addr_o), 32'd0);
    tick();
    check("exc_edge2_inst", dif.inst_o, 32'd0);
    drive(ADDU_B, 32'h00000204, 32'd0, 32'd0);
    tick();
    check("resume_inst_o", dif.inst_o, ADDU_B);
    check("resume_pc_o", dif.pc_o, 32'h00000200);

    // asynchronous reset mid-cycle forces every output low at once
    drive(JR_31, 32'h00000208, 32'h12345678, 32'd0);
    dif.ex_load_i = 1'b1;
    dif.ex_dest_i = 5'd31;
    #1;
    reset_n = 1'b0;
    #1;
    check("arst_inst_o", dif.inst_o, 32'd0);
    check("arst_pc_o", dif.pc_o, 32'd0);
    check("arst_valid", 32'(dif.branch_valid_o), 32'd0);
    check("arst_target", dif.branch_target_o, 32'd0);
    check("arst_stall", 32'(dif.stall_o), 32'd0);
    check("arst_rs_addr", 32'(dif.rs_addr_o), 32'd0);
    #2;
    reset_n = 1'b1;
    drive(ADDU_A, 32'h00000300, 32'd0, 32'd0);
    tick();
    check("post_rst_inst_o", dif.inst_o, ADDU_A);
    check("post_rst_pc_o", dif.pc_o, 32'd0);

`ifdef FAIRY_LOAD_USE_STALL_EN
    // reset while stalled abandons the replay register
    drive(ADDU_A, 32'h00000304, 32'd0, 32'd0);
    dif.ex_load_i = 1'b1;
    dif.ex_dest_i = 5'd8;
    tick();
    check("mid_stall_stall", 32'(dif.stall_o), 32'd1);
    check("mid_stall_rs", 32'(dif.rs_addr_o), 32'd8);
    reset_n = 1'b0;
    #1;
    check("mid_stall_rst_stall", 32'(dif.stall_o), 32'd0);
    #1;
    reset_n = 1'b1;
    drive(ADDU_B, 32'h00000308, 32'd0, 32'd0);
    #1;
    check("mid_stall_new_rs", 32'(dif.rs_addr_o), 32'd0);
    tick();
    check("mid_stall_new_inst", dif.inst_o, ADDU_B);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
